// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game engine.
// Coordinates are packed {y,x} with a run-time coordinate width so one helper serves every grid size.
package snake_pkg;

  localparam int MAX_COORD_W = 8;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    UP    = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PLACE = 2'd1,
    S_OVER  = 2'd2,
    S_WON   = 2'd3
  } state_t;

  // Opposite directions differ only in bit 1 of the encoding.
  function automatic dir_t reverse(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  // Result is {oob,y,x} at coordW bits per field; y grows downward, so UP decrements y.
  function automatic logic [2*MAX_COORD_W:0] step_coord(
    input logic [2*MAX_COORD_W-1:0] coord,
    input dir_t                     dir,
    input logic                     wrap,
    input int                       coordW
  );
    logic [MAX_COORD_W-1:0]   x;
    logic [MAX_COORD_W-1:0]   y;
    logic [MAX_COORD_W-1:0]   top;
    logic                     oob;
    logic [2*MAX_COORD_W:0]   res;
    top = MAX_COORD_W'((1 << coordW) - 1);
    x   = MAX_COORD_W'(coord) & top;
    y   = MAX_COORD_W'(coord >> coordW) & top;
    oob = 1'b0;
    case (dir)
      RIGHT: begin oob = (x == top);  x = (x + 1'b1) & top; end
      LEFT:  begin oob = (x == '0);   x = (x - 1'b1) & top; end
      DOWN:  begin oob = (y == top);  y = (y + 1'b1) & top; end
      UP:    begin oob = (y == '0);   y = (y - 1'b1) & top; end
    endcase
    res = (2*MAX_COORD_W+1)'(oob & ~wrap);
    res = (res << coordW) | (2*MAX_COORD_W+1)'(y);
    res = (res << coordW) | (2*MAX_COORD_W+1)'(x);
    return res;
  endfunction

endpackage

// File: rtl/snake_core_param_body_cam.sv
// Snake body store: shift register of segment cells with two length-masked match ports.
// Port A serves move/food-placement collision checks, port B the renderer query.
module snake_body_cam
  import snake_pkg::*;
#(
  parameter int COORD_W  = 3,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  localparam int IW      = 2*COORD_W,
  localparam int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_shift,
  input  logic [IW-1:0]    i_newHead,
  input  logic [IW-1:0]    i_keyA,
  input  logic [LEN_W-1:0] i_lenA,
  output logic             o_hitA,
  input  logic [IW-1:0]    i_keyB,
  input  logic [LEN_W-1:0] i_lenB,
  output logic             o_hitB,
  output logic [IW-1:0]    o_head
);

  localparam int G = 1 << COORD_W;
  localparam logic [COORD_W-1:0] START_Y = COORD_W'(G/2 - 1);

  logic [IW-1:0] r_segs [MAX_LEN];

  // Reset lays the body out horizontally with the head at the right end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++)
        r_segs[i] <= (i < INIT_LEN) ? {START_Y, COORD_W'(INIT_LEN - 1 - i)} : '0;
    end else if (i_shift) begin
      r_segs[0] <= i_newHead;
      for (int i = 1; i < MAX_LEN; i++)
        r_segs[i] <= r_segs[i-1];
    end
  end

  always_comb begin
    o_hitA = 1'b0;
    o_hitB = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < i_lenA) && (r_segs[i] == i_keyA)) o_hitA = 1'b1;
      if ((LEN_W'(i) < i_lenB) && (r_segs[i] == i_keyB)) o_hitB = 1'b1;
    end
  end

  assign o_head = r_segs[0];

endmodule

// File: rtl/snake_core_param.sv
// Snake game engine: movement, growth, collision, food placement search and win/lose tracking.
// Food search scans one candidate cell per cycle starting at the latched random cell.
module snake_core_param
  import snake_pkg::*;
#(
  parameter int COORD_W  = 3,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int WRAP     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         step,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic [2*COORD_W-1:0]         rnd,
  input  logic [2*COORD_W-1:0]         qry_idx,
  output logic                         qry_body,
  output logic [2*COORD_W-1:0]         idx_head,
  output logic [2*COORD_W-1:0]         idx_food,
  output logic [$clog2(MAX_LEN+1)-1:0] len,
  output logic [7:0]                   score,
  output logic                         busy,
  output logic                         game_over,
  output logic                         game_won
);

  localparam int IW    = 2*COORD_W;
  localparam int G     = 1 << COORD_W;
  localparam int CELLS = G * G;
  localparam int LEN_W = $clog2(MAX_LEN+1);
  localparam int TW    = IW + 1;
  localparam logic [COORD_W-1:0] FOOD_C = COORD_W'(G - 3);

  state_t           r_state,   w_stateNext;
  dir_t             r_dir,     w_dirNext;
  dir_t             r_pendDir, w_pendNext;
  logic [LEN_W-1:0] r_len,     w_lenNext;
  logic [7:0]       r_score,   w_scoreNext;
  logic [IW-1:0]    r_food,    w_foodNext;
  logic [IW-1:0]    r_cand,    w_candNext;
  logic [TW-1:0]    r_tries,   w_triesNext;
  logic             r_busy,    w_busyNext;
  logic             r_over,    w_overNext;
  logic             r_won,     w_wonNext;

  logic             w_reqValid;
  dir_t             w_req;
  logic [IW:0]      w_step;
  logic [IW-1:0]    w_nh;
  logic             w_oob;
  logic             w_eat;
  logic             w_shift;
  logic [IW-1:0]    w_keyA;
  logic [LEN_W-1:0] w_lenA;
  logic             w_hitA;
  logic [IW-1:0]    w_head;

  snake_body_cam #(
    .COORD_W  (COORD_W),
    .MAX_LEN  (MAX_LEN),
    .INIT_LEN (INIT_LEN)
  ) u_cam (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_shift   (w_shift),
    .i_newHead (w_nh),
    .i_keyA    (w_keyA),
    .i_lenA    (w_lenA),
    .o_hitA    (w_hitA),
    .i_keyB    (qry_idx),
    .i_lenB    (r_len),
    .o_hitB    (qry_body),
    .o_head    (w_head)
  );

  // Button priority up > down > left > right; a reversal of the committed heading is ignored.
  always_comb begin
    w_reqValid = 1'b1;
    w_req      = r_pendDir;
    if (btn_up)         w_req = UP;
    else if (btn_down)  w_req = DOWN;
    else if (btn_left)  w_req = LEFT;
    else if (btn_right) w_req = RIGHT;
    else                w_reqValid = 1'b0;
    w_pendNext = (w_reqValid && (w_req != reverse(r_dir))) ? w_req : r_pendDir;
  end

  assign w_step = TW'(step_coord((2*MAX_COORD_W)'(w_head), r_pendDir, WRAP != 0, COORD_W));
  assign w_nh   = w_step[IW-1:0];
  assign w_oob  = w_step[IW];
  assign w_eat  = (w_nh == r_food);

  // The tail cell counts as free on a plain move because it vacates in the same step.
  always_comb begin
    if (r_state == S_PLACE) begin
      w_keyA = r_cand;
      w_lenA = r_len;
    end else begin
      w_keyA = w_nh;
      w_lenA = w_eat ? r_len : r_len - 1'b1;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_dirNext   = r_dir;
    w_lenNext   = r_len;
    w_scoreNext = r_score;
    w_foodNext  = r_food;
    w_candNext  = r_cand;
    w_triesNext = r_tries;
    w_busyNext  = r_busy;
    w_overNext  = r_over;
    w_wonNext   = r_won;
    w_shift     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (step) begin
          if (w_oob || w_hitA) begin
            w_overNext  = 1'b1;
            w_stateNext = S_OVER;
          end else begin
            w_shift   = 1'b1;
            w_dirNext = r_pendDir;
            if (w_eat) begin
              w_lenNext   = r_len + 1'b1;
              w_scoreNext = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
              if (r_len + 1'b1 == LEN_W'(MAX_LEN)) begin
                w_wonNext   = 1'b1;
                w_stateNext = S_WON;
              end else begin
                w_candNext  = rnd;
                w_triesNext = '0;
                w_busyNext  = 1'b1;
                w_stateNext = S_PLACE;
              end
            end
          end
        end
      end
      S_PLACE: begin
        if (!w_hitA) begin
          w_foodNext  = r_cand;
          w_busyNext  = 1'b0;
          w_stateNext = S_RUN;
        end else begin
          w_candNext  = r_cand + 1'b1;
          w_triesNext = r_tries + 1'b1;
          if (r_tries == TW'(CELLS - 1)) begin
            w_wonNext   = 1'b1;
            w_busyNext  = 1'b0;
            w_stateNext = S_WON;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_dir     <= RIGHT;
      r_pendDir <= RIGHT;
      r_len     <= LEN_W'(INIT_LEN);
      r_score   <= '0;
      r_food    <= {FOOD_C, FOOD_C};
      r_cand    <= '0;
      r_tries   <= '0;
      r_busy    <= 1'b0;
      r_over    <= 1'b0;
      r_won     <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_dir     <= w_dirNext;
      r_pendDir <= w_pendNext;
      r_len     <= w_lenNext;
      r_score   <= w_scoreNext;
      r_food    <= w_foodNext;
      r_cand    <= w_candNext;
      r_tries   <= w_triesNext;
      r_busy    <= w_busyNext;
      r_over    <= w_overNext;
      r_won     <= w_wonNext;
    end
  end

  assign idx_head  = w_head;
  assign idx_food  = r_food;
  assign len       = r_len;
  assign score     = r_score;
  assign busy      = r_busy;
  assign game_over = r_over;
  assign game_won  = r_won;

endmodule
